debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Multi-channel debounce/glitch filter with programmable hysteresis length.
//  Each channel drives a registered stable level. That level flips only after the
//  raw input has disagreed with it for THRESH consecutive clocks.
//  Each channel also provides one-cycle rise/fall pulses.
//  Sits between pad inputs (buttons, SCL/SDA, straps) and control logic.
//  Supersedes the fixed-window shift-register filter.
// PARAMETERS
//  CHANNELS   4     number of independent filter channels
//  CNT_W      8     counter width; max usable threshold 2**CNT_W-1
//  RESET_VAL  '0    CHANNELS-bit reset value of the stable levels
// PORTS
//  clk      in   1         single clock, all logic rising-edge
//  rstn     in   1         asynchronous active-low reset
//  thresh   in   CNT_W     consecutive-mismatch clocks required to flip; shared by all channels
//  i        in   CHANNELS  raw inputs
//  o        out  CHANNELS  filtered stable levels
//  rise     out  CHANNELS  1-clk pulse when o[n] goes 0->1
//  fall     out  CHANNELS  1-clk pulse when o[n] goes 1->0
//  changed  out  1         OR of all rise|fall bits, registered together with them
// BEHAVIOUR
//  - Reset (async assert, release on clk):
//    o=RESET_VAL; rise=fall=changed=0; counters=0; sample regs=RESET_VAL.
//  - Per channel, sample register s[n] <= i[n] every clk, placed after the optional synchronizer.
//  - Effective threshold thr = (thresh==0) ? 1 : thresh.
//  - Each clk, per channel:
//      s==o             : cnt<=0; no pulse
//      s!=o, cnt>=thr-1 : o<=s; cnt<=0; rise/fall<=1 for this clk
//      s!=o, otherwise  : cnt<=cnt+1 (never wraps: the compare fires first)
//  - rise/fall/changed are 0 on every clk without a flip.
//  - Latency:
//      i stable from edge E0 (captured into s at E0) -> o updates at edge E0+thr;
//      rise/fall are high during the clk after that edge.
//  - A glitch shorter than thr clks resets the count when s returns to o; o does not move.
//  - Threshold change mid-count takes effect next clk. Because the test is >=,
//    lowering thresh below the current cnt flips on the next mismatching clk.
//  - Channels are fully independent. Simultaneous flips on several channels all pulse
//    in the same clk; changed=1.
//  - Reset mid-count discards the count; o returns to RESET_VAL with no pulse.
// CONFIGURATION
//  DEBOUNCE_SYNC_EN defined:
//    2-flop synchronizer per channel in front of s, reset to RESET_VAL.
//    Latency from the pin grows by 2 clks. i may be asynchronous.
//  DEBOUNCE_SYNC_EN undefined:
//    i feeds s directly. i must be synchronous to clk; latency as above.
// STRUCTURE
//  - Package debounce_pkg:
//      localparam DEFAULT_CNT_W;
//      typedef enum logic [1:0] {EV_NONE, EV_RISE, EV_FALL} debounce_ev_t;
//      function eff_thresh(), which maps 0 to 1.
//  - Sub-module debounce_chan:
//      one channel (sync, s, cnt, o, event);
//      instantiated CHANNELS times by generate.
//  - The top only fans out thresh and ORs the events into changed.
// TESTING
//  1 Reset: rstn=0 with i toggling, RESET_VAL=4'b0101
//    -> o=0101, rise=fall=changed=0 throughout; no pulse at release.
//  2 thresh=4, i[0] 0->1 held
//    -> o[0]=1 exactly 4 clks after s[0] rises; rise[0] high 1 clk; changed high same clk.
//  3 thresh=4, i[1] high for 3 clks, low, then high for 3 clks
//    -> o[1] stays 0; no pulses; cnt returns to 0.
//  4 thresh=0, i[2] toggles every clk
//    -> o[2] follows s[2] with 1-clk delay; rise/fall alternate every clk.
//  5 thresh=10, mismatch for 6 clks, then thresh=3
//    -> o flips on the next clk; single fall or rise pulse.
//  6 All channels flip in the same clk, then rstn pulsed low mid-count on the next transition
//    -> all rise in one clk; after reset o=RESET_VAL and counters restart from 0.
//  Run 1-6 with DEBOUNCE_SYNC_EN both defined and undefined; expect +2 clk latency when defined.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_bank filter.
package debounce_pkg;

  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_RISE,
    EV_FALL
  } debounce_ev_t;

  // A zero threshold behaves as one so a channel can never stall.
  function automatic logic [31:0] eff_thresh(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: optional 2-flop synchronizer, sample reg, mismatch
// counter, stable level and edge events.
// Build option: define DEBOUNCE_SYNC_EN to add the input synchronizer.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W     = DEFAULT_CNT_W,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] thresh,
  input  logic             i,
  output logic             o,
  output logic             rise,
  output logic             fall,
  output logic             flip_c
);

  logic             din;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] thr_m1;
  debounce_ev_t     ev_c;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer for pad inputs that may be asynchronous.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= {2{RESET_VAL}};
    else       sync_q <= {sync_q[0], i};
  end

  assign din = sync_q[1];
`else
  assign din = i;
`endif

  // Effective threshold and the flip decision for this clock.
  always_comb begin
    thr    = CNT_W'(eff_thresh(32'(thresh)));
    thr_m1 = thr - CNT_W'(1);
    ev_c   = EV_NONE;
    flip_c = 1'b0;
    if ((s != o) && (cnt >= thr_m1)) begin
      flip_c = 1'b1;
      ev_c   = s ? EV_RISE : EV_FALL;
    end
  end

  // Sample, count consecutive disagreement, flip the level and pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s    <= RESET_VAL;
      o    <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s    <= din;
      rise <= (ev_c == EV_RISE);
      fall <= (ev_c == EV_FALL);
      if (s == o) begin
        cnt <= '0;
      end else if (flip_c) begin
        o   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debounce / glitch filter with a shared programmable threshold.
// Build option: define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer on each
// input (adds 2 clocks of latency, allows asynchronous inputs).
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned         CHANNELS  = 4,
  parameter int unsigned         CNT_W     = DEFAULT_CNT_W,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CNT_W-1:0]    thresh,
  input  logic [CHANNELS-1:0] i,
  output logic [CHANNELS-1:0] o,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  logic [CHANNELS-1:0] flip_c;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    debounce_chan #(
      .CNT_W     (CNT_W),
      .RESET_VAL (RESET_VAL[n])
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .thresh (thresh),
      .i      (i[n]),
      .o      (o[n]),
      .rise   (rise[n]),
      .fall   (fall[n]),
      .flip_c (flip_c[n])
    );
  end

  // Any channel flipping this clock raises changed alongside its pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) changed <= 1'b0;
    else       changed <= |flip_c;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed scoreboard bench for debounce_bank (either DEBOUNCE_SYNC_EN build).
module tb_debounce_bank;

`ifdef DEBOUNCE_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  localparam logic [3:0] RV = 4'b0101;

  logic       clk;
  logic       rstn;
  logic [7:0] thresh;
  logic [3:0] i;
  logic [3:0] o;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } exp_t;

  exp_t  q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  string tag;

  debounce_bank #(
    .CHANNELS  (4),
    .CNT_W     (8),
    .RESET_VAL (RV)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .thresh  (thresh),
    .i       (i),
    .o       (o),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [3:0] eo, input logic [3:0] er,
                          input logic [3:0] ef, input logic ec);
    exp_t e;
    e.o = eo; e.rise = er; e.fall = ef; e.chg = ec;
    q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    e = q.pop_front();
    n_cmp++;
    assert (o === e.o) else begin
      n_mis++;
      $error("FAIL %s o: observed %b expected %b", tag, o, e.o);
    end
    n_cmp++;
    assert (rise === e.rise) else begin
      n_mis++;
      $error("FAIL %s rise: observed %b expected %b", tag, rise, e.rise);
    end
    n_cmp++;
    assert (fall === e.fall) else begin
      n_mis++;
      $error("FAIL %s fall: observed %b expected %b", tag, fall, e.fall);
    end
    n_cmp++;
    assert (changed === e.chg) else begin
      n_mis++;
      $error("FAIL %s changed: observed %b expected %b", tag, changed, e.chg);
    end
  endtask

  // Push n expectations, one per clock, each checked 1 time unit after the edge.
  task automatic hold(input int n, input logic [3:0] eo, input logic [3:0] er,
                      input logic [3:0] ef, input logic ec);
    for (int k = 0; k < n; k++) begin
      push_exp(eo, er, ef, ec);
      @(posedge clk);
      #1;
      check_front();
    end
  endtask

  initial begin
    logic       v [1:12];
    logic       vv;
    logic       pv;
    logic [3:0] er;
    logic [3:0] ef;

    rstn   = 1'b0;
    thresh = 8'd4;
    i      = 4'b0000;

    // 1: reset holds RESET_VAL while inputs toggle; no pulse on release
    tag = "reset";
    for (int k = 0; k < 5; k++) begin
      i = 4'(k * 5 + 3);
      hold(1, RV, 4'b0000, 4'b0000, 1'b0);
    end
    i    = RV;
    rstn = 1'b1;
    tag  = "release";
    hold(6, RV, 4'b0000, 4'b0000, 1'b0);

    // 2: thresh=4, ch0 falls then rises after exactly thr clocks
    tag = "ch0_fall";
    i   = 4'b0100;
    hold(3 + D, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    hold(1,     4'b0100, 4'b0000, 4'b0001, 1'b1);
    hold(2,     4'b0100, 4'b0000, 4'b0000, 1'b0);
    tag = "ch0_rise";
    i   = 4'b0101;
    hold(3 + D, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    hold(1,     4'b0101, 4'b0001, 4'b0000, 1'b1);
    hold(2,     4'b0101, 4'b0000, 4'b0000, 1'b0);

    // 3: two 3-clock glitches on ch1 never flip; a full hold flips on time
    tag = "glitch";
    i = 4'b0111; hold(3, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    i = 4'b0101; hold(1, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    i = 4'b0111; hold(3, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    i = 4'b0101; hold(D + 4, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    tag = "post_glitch";
    i = 4'b0111;
    hold(3 + D, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    hold(1,     4'b0111, 4'b0010, 4'b0000, 1'b1);
    hold(2,     4'b0111, 4'b0000, 4'b0000, 1'b0);

    // 4: thresh=0 acts as 1; ch2 toggling every clock is followed
    tag    = "thr0_toggle";
    thresh = 8'd0;
    for (int k = 1; k <= 12; k++) v[k] = (k <= 8) ? ((k % 2) == 0) : 1'b1;
    for (int k = 1; k <= 12; k++) begin
      i[2] = v[k];
      if (k <= D) begin
        push_exp(4'b0111, 4'b0000, 4'b0000, 1'b0);
      end else begin
        vv = v[k - D];
        pv = (k - D > 1) ? v[k - D - 1] : 1'b1;
        er = (vv && !pv) ? 4'b0100 : 4'b0000;
        ef = (!vv && pv) ? 4'b0100 : 4'b0000;
        push_exp({1'b0, vv, 2'b11}, er, ef, (vv != pv));
      end
      @(posedge clk);
      #1;
      check_front();
    end

    // 5: thresh=10 counting, then lowered to 3 below the count -> flip next clock
    tag    = "thr_lower";
    thresh = 8'd10;
    i      = 4'b1111;
    hold(D + 6, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    thresh = 8'd3;
    hold(1,     4'b1111, 4'b1000, 4'b0000, 1'b1);
    hold(2,     4'b1111, 4'b0000, 4'b0000, 1'b0);

    // 6: all channels flip together, then reset mid-count
    tag    = "all_fall";
    thresh = 8'd4;
    i      = 4'b0000;
    hold(3 + D, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    hold(1,     4'b0000, 4'b0000, 4'b1111, 1'b1);
    hold(1,     4'b0000, 4'b0000, 4'b0000, 1'b0);
    tag = "all_rise";
    i   = 4'b1111;
    hold(3 + D, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    hold(1,     4'b1111, 4'b1111, 4'b0000, 1'b1);
    hold(1,     4'b1111, 4'b0000, 4'b0000, 1'b0);
    tag = "mid_count";
    i   = 4'b0000;
    hold(D + 2, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tag  = "async_rst";
    rstn = 1'b0;
    #1;
    push_exp(RV, 4'b0000, 4'b0000, 1'b0);
    check_front();
    hold(2, RV, 4'b0000, 4'b0000, 1'b0);
    tag  = "restart";
    rstn = 1'b1;
    hold(3 + D, RV,      4'b0000, 4'b0000, 1'b0);
    hold(1,     4'b0000, 4'b0000, 4'b0101, 1'b1);
    hold(2,     4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
